// File: rtl/fsgn_pkg.sv
// Shared types and combinational helpers for the fsgn_pipe sign-manipulation unit.
// fclass10 is only referenced when FSGN_CLASS_EN is defined.
package fsgn_pkg;

    localparam int unsigned STAGES_MAX = 4;

    typedef enum logic [2:0] {
        FABS   = 3'd0,
        FNEG   = 3'd1,
        FSGNJ  = 3'd2,
        FSGNJN = 3'd3,
        FSGNJX = 3'd4,
        FMV    = 3'd5
    } fsgn_op_e;

    typedef struct packed {
        logic sign;
        logic illegal;
    } fsgn_res_t;

    // Only the sign bits matter; the caller splices the sign back onto x's magnitude.
    function automatic fsgn_res_t fsgn_calc(input logic [2:0] op, input logic x_sign,
                                            input logic z_sign);
        fsgn_res_t r;
        r.illegal = 1'b0;
        r.sign    = x_sign;
        case (op)
            FABS:    r.sign = 1'b0;
            FNEG:    r.sign = ~x_sign;
            FSGNJ:   r.sign = z_sign;
            FSGNJN:  r.sign = ~z_sign;
            FSGNJX:  r.sign = x_sign ^ z_sign;
            FMV:     r.sign = x_sign;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    // RISC-V fclass one-hot; y is zero-extended, dbl selects the binary64 field layout.
    function automatic logic [9:0] fclass10(input logic [63:0] y, input logic dbl);
        logic s, e_max, e_zero, m_zero, quiet;
        logic [9:0] c;
        if (dbl) begin
            s      = y[63];
            e_max  = &y[62:52];
            e_zero = ~|y[62:52];
            m_zero = ~|y[51:0];
            quiet  = y[51];
        end else begin
            s      = y[31];
            e_max  = &y[30:23];
            e_zero = ~|y[30:23];
            m_zero = ~|y[22:0];
            quiet  = y[22];
        end
        if (e_max && m_zero)       c = s ? 10'h001 : 10'h080;
        else if (e_max)            c = quiet ? 10'h200 : 10'h100;
        else if (e_zero && m_zero) c = s ? 10'h008 : 10'h010;
        else if (e_zero)           c = s ? 10'h004 : 10'h020;
        else                       c = s ? 10'h002 : 10'h040;
        return c;
    endfunction

endpackage

// File: rtl/fsgn_pipe_if.sv
// Request/result handshake bundle for fsgn_pipe; out_class exists only with FSGN_CLASS_EN.
interface fsgn_pipe_if #(
    parameter int unsigned FLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [FLEN-1:0]  in_x;
    logic [FLEN-1:0]  in_z;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [FLEN-1:0]  out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
`ifdef FSGN_CLASS_EN
    logic [9:0]       out_class;
`endif

    modport master (
        output in_valid, in_op, in_x, in_z, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_tag, out_illegal
`ifdef FSGN_CLASS_EN
        , input out_class
`endif
    );

    modport slave (
        input  in_valid, in_op, in_x, in_z, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_tag, out_illegal
`ifdef FSGN_CLASS_EN
        , output out_class
`endif
    );
endinterface

// File: rtl/fsgn_stage.sv
// One pipeline slice: loads upstream valid/payload when told to advance, otherwise holds.
module fsgn_stage #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    output logic         valid,
    output logic [W-1:0] data
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= up_valid;
            data  <= up_data;
        end
    end
endmodule

// File: rtl/fsgn_pipe.sv
// fsgn_pipe: FABS/FNEG/FSGNJ/FSGNJN/FSGNJX/FMV unit with STAGES-deep valid/ready pipeline.
// Defining FSGN_CLASS_EN adds a pipelined RISC-V fclass result (out_class).
module fsgn_pipe
    import fsgn_pkg::*;
#(
    parameter int unsigned FLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 5
) (
    input logic       sys_clk,
    input logic       rst,
    fsgn_pipe_if.slave bus
);
`ifdef FSGN_CLASS_EN
    localparam int unsigned CLW = 10;
`else
    localparam int unsigned CLW = 0;
`endif
    localparam int unsigned PW = CLW + 1 + TAG_W + FLEN;

    fsgn_res_t         res;
    logic [FLEN-1:0]   y0;
    logic [PW-1:0]     d0;
    logic              acc;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [PW-1:0]     d [STAGES];

    if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("fsgn_pipe: STAGES must be 1..%0d", STAGES_MAX);
    end

    always_comb res = fsgn_calc(bus.in_op, bus.in_x[FLEN-1], bus.in_z[FLEN-1]);
    assign y0 = {res.sign, bus.in_x[FLEN-2:0]};

`ifdef FSGN_CLASS_EN
    if (FLEN != 32 && FLEN != 64) begin : g_bad_flen
        $error("fsgn_pipe: FSGN_CLASS_EN supports FLEN 32 or 64 only");
    end
    assign d0 = {fclass10(64'(y0), FLEN == 64), res.illegal, bus.in_tag, y0};
`else
    assign d0 = {res.illegal, bus.in_tag, y0};
`endif

    assign acc          = bus.in_valid & adv[0];
    assign bus.in_ready = adv[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic          up_v;
        logic [PW-1:0] up_d;

        // Equivalent to the ripple "next advances or I am empty": any hole downstream
        // (or a pop) lets this slot move; derived from registers only, so no comb chain.
        assign adv[i] = bus.out_ready | ~(&v[STAGES-1:i]);

        if (i == 0) begin : g_first
            assign up_v = acc;
            assign up_d = d0;
        end else begin : g_next
            assign up_v = v[i-1];
            assign up_d = d[i-1];
        end

        fsgn_stage #(.W(PW)) u_stage (
            .clk     (sys_clk),
            .rst     (rst),
            .load    (adv[i]),
            .up_valid(up_v),
            .up_data (up_d),
            .valid   (v[i]),
            .data    (d[i])
        );
    end

    assign bus.out_valid   = v[STAGES-1];
    assign bus.out_y       = d[STAGES-1][FLEN-1:0];
    assign bus.out_tag     = d[STAGES-1][FLEN +: TAG_W];
    assign bus.out_illegal = d[STAGES-1][FLEN+TAG_W];
`ifdef FSGN_CLASS_EN
    assign bus.out_class   = d[STAGES-1][FLEN+TAG_W+1 +: 10];
`endif
endmodule

// File: tb/tb_fsgn_pipe.sv
// Scoreboard bench for fsgn_pipe (STAGES=3): driver pushes model results on acceptance,
// monitor compares whatever the DUT presents. Covers FSGN_CLASS_EN when defined.
module tb_fsgn_pipe;
    localparam int unsigned FLEN   = 32;
    localparam int unsigned STAGES = 3;
    localparam int unsigned TAG_W  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsgn_pipe_if #(.FLEN(FLEN), .TAG_W(TAG_W)) bus ();

    fsgn_pipe #(.FLEN(FLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .sys_clk(clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [31:0] y;
        logic [4:0]  tag;
        logic        ill;
        logic [9:0]  cls;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // fclass from IEEE-754 binary32 field meanings.
    function automatic logic [9:0] ref_class(input logic [31:0] y);
        int e = int'(y[30:23]);
        int m = int'(y[22:0]);
        bit neg = y[31];
        int k;
        if (e == 255 && m == 0) k = neg ? 0 : 7;
        else if (e == 255)      k = y[22] ? 9 : 8;
        else if (e == 0 && m == 0) k = neg ? 3 : 4;
        else if (e == 0)        k = neg ? 2 : 5;
        else                    k = neg ? 1 : 6;
        return 10'd1 << k;
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] z,
                                   input logic [4:0] tag);
        exp_t e;
        bit s;
        e.ill = 1'b0;
        case (op)
            3'd0: s = 1'b0;
            3'd1: s = !x[31];
            3'd2: s = z[31];
            3'd3: s = !z[31];
            3'd4: s = x[31] ^ z[31];
            3'd5: s = x[31];
            default: begin s = x[31]; e.ill = 1'b1; end
        endcase
        e.y   = (x & 32'h7FFF_FFFF) | (s ? 32'h8000_0000 : 32'h0);
        e.tag = tag;
        e.cls = ref_class(e.y);
        e.acc = cyc;
        e.lat = lat_chk;
        return e;
    endfunction

    // Monitor: compare the output slot against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got tag %0d y %0h, expected no output", bus.out_tag, bus.out_y);
            end else begin
                mon_e = q[0];
                check("out_y", 64'(bus.out_y), 64'(mon_e.y));
                check("out_tag", 64'(bus.out_tag), 64'(mon_e.tag));
                check("out_illegal", 64'(bus.out_illegal), 64'(mon_e.ill));
`ifdef FSGN_CLASS_EN
                check("out_class", 64'(bus.out_class), 64'(mon_e.cls));
`endif
                if (bus.out_ready) begin
                    if (mon_e.lat) check("latency", 64'(cyc - mon_e.acc), 64'(STAGES));
                    void'(q.pop_front());
                end
            end
        end
    end

    // All driver tasks start and end just after a rising edge.
    task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] z,
                        input logic [4:0] tag, output int retries);
        retries = 0;
        bus.in_op = op; bus.in_x = x; bus.in_z = z; bus.in_tag = tag; bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back(model(op, x, z, tag));
                @(posedge clk); #1;
                break;
            end
            retries++;
            if (retries > 100) begin
                check("send_timeout", 64'(retries), 64'(0));
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid = 1'b0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    // Single op into an empty pipe; result checked against literal constants.
    task automatic direct(input string name, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] z, input logic [4:0] tag, input logic [31:0] y_exp,
                          input logic ill_exp, input logic [9:0] cls_exp);
        int r;
        int k = 0;
        send(op, x, z, tag, r);
        bus.in_valid = 1'b0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 20);
        check({name, "_lat"}, 64'(k), 64'(STAGES));
        check({name, "_y"}, 64'(bus.out_y), 64'(y_exp));
        check({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        check({name, "_ill"}, 64'(bus.out_illegal), 64'(ill_exp));
`ifdef FSGN_CLASS_EN
        check({name, "_class"}, 64'(bus.out_class), 64'(cls_exp));
`else
        if (cls_exp === 10'h3FF) check({name, "_class_arg"}, 64'(cls_exp), 64'(0));
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    initial begin
        int r, acc_n, outs;
        logic [2:0]  op;
        logic [31:0] x, z;
        logic [4:0]  tag;
        bit          last_ready, take_new;

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_x = '0; bus.in_z = '0; bus.in_tag = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_y", 64'(bus.out_y), 64'(0));
        check("rst_out_tag", 64'(bus.out_tag), 64'(0));
        check("rst_out_illegal", 64'(bus.out_illegal), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
`ifdef FSGN_CLASS_EN
        check("rst_out_class", 64'(bus.out_class), 64'(0));
`endif
        @(posedge clk); #1;

        lat_chk = 1'b1;
        direct("fabs", 3'd0, 32'hC049_0FDB, 32'h0, 5'd3, 32'h4049_0FDB, 1'b0, 10'h040);
        direct("fsgnjx", 3'd4, 32'hBF80_0000, 32'h8000_0000, 5'd9, 32'h3F80_0000, 1'b0, 10'h040);
        direct("fneg_nan", 3'd1, 32'h7FC0_0001, 32'h0, 5'd10, 32'hFFC0_0001, 1'b0, 10'h200);
        direct("op6", 3'd6, 32'h1234_5678, 32'hFFFF_FFFF, 5'd11, 32'h1234_5678, 1'b1, 10'h040);
        direct("op7", 3'd7, 32'h8000_0001, 32'h0, 5'd12, 32'h8000_0001, 1'b1, 10'h004);
        direct("fabs_ninf", 3'd0, 32'hFF80_0000, 32'h0, 5'd13, 32'h7F80_0000, 1'b0, 10'h080);

        // Back-to-back burst, tags 0..7: every request accepted on first try.
        for (int t = 0; t < 8; t++) begin
            send(3'($urandom_range(0, 5)), $urandom, $urandom, 5'(t), r);
            check("burst_in_ready", 64'(r), 64'(0));
        end
        drain();

        // Output stalled while input stays valid: the pipe must absorb exactly STAGES ops.
        lat_chk = 1'b0;
        bus.out_ready = 1'b0;
        acc_n = 0;
        take_new = 1'b1;
        last_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (take_new) begin
                op = 3'($urandom_range(0, 7)); x = $urandom; z = $urandom; tag = 5'(20 + c);
            end
            bus.in_op = op; bus.in_x = x; bus.in_z = z; bus.in_tag = tag; bus.in_valid = 1'b1;
            @(negedge clk);
            last_ready = bus.in_ready;
            take_new = bus.in_ready;
            if (bus.in_ready) begin
                q.push_back(model(op, x, z, tag));
                acc_n++;
            end
            @(posedge clk); #1;
        end
        check("stall_accepted", 64'(acc_n), 64'(STAGES));
        check("stall_in_ready", 64'(last_ready), 64'(0));
        bus.out_ready = 1'b1;
        drain();

        // Randomised traffic with random backpressure and special float encodings.
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            x = $urandom;
            z = $urandom;
            case ($urandom_range(0, 5))
                0: x[30:23] = 8'hFF;
                1: x[30:23] = 8'h00;
                2: x[22:0] = '0;
                default: ;
            endcase
            bus.in_op = 3'($urandom_range(0, 7)); bus.in_x = x; bus.in_z = z;
            bus.in_tag = 5'($urandom); bus.in_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_op, bus.in_x, bus.in_z, bus.in_tag));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        drain();

        // Reset with two ops in flight plus a request in the reset cycle: none may emerge.
        send(3'd1, 32'h3F80_0000, 32'h0, 5'd30, r);
        send(3'd0, 32'hBF80_0000, 32'h0, 5'd31, r);
        rst = 1'b1;
        bus.in_op = 3'd5; bus.in_x = 32'h0BAD_F00D; bus.in_tag = 5'd17; bus.in_valid = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(bus.out_valid), 64'(0));
        check("flush_in_ready", 64'(bus.in_ready), 64'(1));
        outs = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) outs++;
        end
        check("flush_no_output", 64'(outs), 64'(0));
        @(posedge clk); #1;

        check("final_queue_empty", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
